// File: rtl/plusarg_watchdog.sv
// Multi-channel forward-progress watchdog with a runtime stall limit and a sticky timeout.
// Optional build macro PLUSARG_WATCHDOG_FATAL_EN ends a simulation at the trip edge.
module plusarg_watchdog #(
  parameter int N     = 4,
  parameter int CNT_W = 32,
  parameter int IDX_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      limit,
  input  logic             enable,
  input  logic [N-1:0]     active,
  input  logic [N-1:0]     progress,
  input  logic             clear,
  output logic             armed,
  output logic             timeout,
  output logic [IDX_W-1:0] timeout_chan,
  output logic             timeout_pulse,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_ARMED    = 2'd1,
    S_TRIPPED  = 2'd2
  } state_t;

  localparam logic [32:0]      CNT_MAX = (33'd1 << CNT_W) - 33'd1;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     over;
  logic             limit_reachable;
  logic             limit_zero;
  logic             trip;
  logic [IDX_W-1:0] trip_chan;

  assign dbg_state = state_q;

  // A limit the counter can never reach must not trip on a saturated count.
  always_comb begin
    limit_reachable = ({1'b0, limit} <= CNT_MAX);
    limit_zero      = (limit == 32'd0);
    for (int i = 0; i < N; i++) begin
      over[i] = active[i] & ~progress[i] & limit_reachable &
                ((33'(cnt_q[i]) + 33'd1) >= {1'b0, limit});
    end
  end

  always_comb begin
    trip_chan = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (over[i]) begin
        trip_chan = IDX_W'(i);
      end
    end
  end

  // Disable beats trip (limit==0 would otherwise satisfy the compare); clear beats trip.
  assign trip = (state_q == S_ARMED) & enable & ~limit_zero & ~clear & (|over);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DISABLED: begin
        if (enable && !limit_zero) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!enable || limit_zero) state_d = S_DISABLED;
        else if (trip)             state_d = S_TRIPPED;
      end
      S_TRIPPED: begin
        if (clear)        state_d = S_ARMED;
        else if (!enable) state_d = S_DISABLED;
      end
      default: state_d = S_DISABLED;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (state_q == S_DISABLED || clear) begin
        cnt_d[i] = '0;
      end else if (progress[i] || !active[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CNT_SAT) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_DISABLED;
      armed         <= 1'b0;
      timeout       <= 1'b0;
      timeout_chan  <= '0;
      timeout_pulse <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      armed         <= (state_d == S_ARMED);
      timeout       <= (state_d == S_TRIPPED);
      timeout_pulse <= trip;
      if (trip) begin
        timeout_chan <= trip_chan;
      end
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef PLUSARG_WATCHDOG_FATAL_EN
`ifndef SYNTHESIS
  logic [32:0] stall_len;

  always_comb begin
    stall_len = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (over[i]) begin
        stall_len = 33'(cnt_q[i]) + 33'd1;
      end
    end
  end

  always @(posedge clock) begin
    if (reset_n && trip) begin
      $display("watchdog: channel %d stalled %d cycles", trip_chan, stall_len);
      $fatal(1);
    end
  end
`endif
`else
  // Default build: a trip is reported through the outputs only.
`endif

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Bench for plusarg_watchdog: vector table plus hand sequences, checked through an expected queue.
module tb_plusarg_watchdog;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] limit;
  logic        enable;
  logic [3:0]  active;
  logic [3:0]  progress;
  logic        clear;

  logic       armed_a, timeout_a, pulse_a;
  logic [4:0] chan_a;
  logic [1:0] state_a;
  logic       armed_b, timeout_b, pulse_b;
  logic [4:0] chan_b;
  logic [1:0] state_b;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  localparam logic [7:0] FULL   = 8'hFF;
  localparam logic [7:0] NOCHAN = 8'hC1;

  typedef struct {
    logic [31:0] lim;
    logic        en;
    logic [3:0]  act;
    logic [3:0]  prog;
    logic        clr;
    logic [7:0]  exp;
    logic [7:0]  mask;
  } vec_t;

  vec_t tbl[13];

  plusarg_watchdog #(.N(4), .CNT_W(32), .IDX_W(5)) dut_a (
    .clock(clock), .reset_n(reset_n), .limit(limit), .enable(enable),
    .active(active), .progress(progress), .clear(clear),
    .armed(armed_a), .timeout(timeout_a), .timeout_chan(chan_a),
    .timeout_pulse(pulse_a), .dbg_state(state_a)
  );

  plusarg_watchdog #(.N(4), .CNT_W(4), .IDX_W(5)) dut_b (
    .clock(clock), .reset_n(reset_n), .limit(limit), .enable(enable),
    .active(active), .progress(progress), .clear(clear),
    .armed(armed_b), .timeout(timeout_b), .timeout_chan(chan_b),
    .timeout_pulse(pulse_b), .dbg_state(state_b)
  );

  // clock / reset
  always #5 clock = ~clock;

  function automatic logic [7:0] pk(input logic a, input logic t, input logic [4:0] c, input logic p);
    return {a, t, c, p};
  endfunction

  function automatic vec_t mk(input logic [31:0] lim, input logic en, input logic [3:0] act,
                              input logic [3:0] prog, input logic clr, input logic [7:0] exp,
                              input logic [7:0] mask);
    vec_t v;
    v.lim = lim; v.en = en; v.act = act; v.prog = prog; v.clr = clr; v.exp = exp; v.mask = mask;
    return v;
  endfunction

  // scoreboard
  task automatic check_now(input string name, input logic sel_b, input logic [7:0] mask);
    logic [7:0] e;
    logic [7:0] got;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e   = exp_q.pop_front();
    got = sel_b ? {armed_b, timeout_b, chan_b, pulse_b} : {armed_a, timeout_a, chan_a, pulse_a};
    if ((got & mask) !== (e & mask)) begin
      failures++;
      $display("FAIL %s: got armed/timeout/chan/pulse=%b/%b/%0d/%b expected %b/%b/%0d/%b (mask %h) at %0t",
               name, got[7], got[6], got[5:1], got[0], e[7], e[6], e[5:1], e[0], mask, $time);
    end
  endtask

  // driver: called just after a rising edge; drives, pushes expectation, checks after the next edge
  task automatic step(input string name, input logic [31:0] lim, input logic en, input logic [3:0] act,
                      input logic [3:0] prog, input logic clr, input logic sel_b,
                      input logic [7:0] exp, input logic [7:0] mask);
    limit = lim; enable = en; active = act; progress = prog; clear = clr;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    check_now(name, sel_b, mask);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    enable = 1'b0; active = '0; progress = '0; clear = 1'b0;
    #1;
    exp_q.push_back(8'h00);
    check_now("rst_async_a", 1'b0, FULL);
    exp_q.push_back(8'h00);
    check_now("rst_async_b", 1'b1, FULL);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    limit = '0; enable = 1'b0; active = '0; progress = '0; clear = 1'b0;
    @(posedge clock);
    #1;
    exp_q.push_back(8'h00);
    check_now("reset_state_a", 1'b0, FULL);
    exp_q.push_back(8'h00);
    check_now("reset_state_b", 1'b1, FULL);
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic trip at limit=10 on channel 0, then clear.
    tbl[0] = mk(32'd10, 1'b1, 4'b0000, 4'b0000, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), FULL);
    for (int k = 0; k < 10; k++) begin
      tbl[k+1] = mk(32'd10, 1'b1, 4'b0001, 4'b0000, 1'b0,
                    pk(k < 9, k == 9, 5'd0, k == 9), FULL);
    end
    tbl[11] = mk(32'd10, 1'b1, 4'b0001, 4'b0000, 1'b0, pk(1'b0, 1'b1, 5'd0, 1'b0), FULL);
    tbl[12] = mk(32'd10, 1'b1, 4'b0001, 4'b0000, 1'b1, pk(1'b1, 1'b0, 5'd0, 1'b0), NOCHAN);
    foreach (tbl[i]) begin
      step("t1_vec", tbl[i].lim, tbl[i].en, tbl[i].act, tbl[i].prog, tbl[i].clr, 1'b0,
           tbl[i].exp, tbl[i].mask);
    end

    // Periodic progress keeps channel 2 alive; trip 10 cycles after pulses stop.
    do_reset();
    step("t2_arm", 32'd10, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), FULL);
    for (int j = 0; j <= 108; j++) begin
      step("t2_prog", 32'd10, 1'b1, 4'b0100,
           (j < 100 && (j % 9) == 8) ? 4'b0100 : 4'b0000, 1'b0, 1'b0,
           pk(j < 108, j == 108, (j == 108) ? 5'd2 : 5'd0, j == 108), FULL);
    end

    // Simultaneous stalls on 1 and 3: lowest wins; clear, clear-vs-trip, then 3 re-trips.
    do_reset();
    step("t3_arm", 32'd5, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), FULL);
    for (int j = 0; j < 5; j++) begin
      step("t3_dual", 32'd5, 1'b1, 4'b1010, 4'b0000, 1'b0, 1'b0,
           pk(j < 4, j == 4, (j == 4) ? 5'd1 : 5'd0, j == 4), FULL);
    end
    step("t3_clear", 32'd5, 1'b1, 4'b1010, 4'b0000, 1'b1, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), NOCHAN);
    for (int j = 0; j < 4; j++) begin
      step("t3_pre", 32'd5, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), NOCHAN);
    end
    step("t3_clr_wins", 32'd5, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), NOCHAN);
    for (int j = 0; j < 5; j++) begin
      step("t3_retrip", 32'd5, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0,
           pk(j < 4, j == 4, 5'd3, j == 4), (j == 4) ? FULL : NOCHAN);
    end

    // limit=0 keeps the watchdog disabled; limit=4 arms and trips; enable=0 drops the trip.
    do_reset();
    for (int j = 0; j < 1000; j++) begin
      step("t4_lim0", 32'd0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, pk(1'b0, 1'b0, 5'd0, 1'b0), FULL);
    end
    step("t4_arm", 32'd4, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), FULL);
    for (int j = 0; j < 4; j++) begin
      step("t4_trip", 32'd4, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0,
           pk(j < 3, j == 3, 5'd0, j == 3), FULL);
    end
    step("t4_disable", 32'd4, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, pk(1'b0, 1'b0, 5'd0, 1'b0), NOCHAN);

    // Lowering the limit below a running count trips at once; limit=0 in ARMED disables, no trip.
    step("t4_rearm", 32'd10, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), NOCHAN);
    for (int j = 0; j < 6; j++) begin
      step("t4_count", 32'd10, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), NOCHAN);
    end
    step("t4_lower", 32'd3, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, pk(1'b0, 1'b1, 5'd1, 1'b1), FULL);
    step("t4_clear", 32'd3, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, pk(1'b1, 1'b0, 5'd1, 1'b0), NOCHAN);
    step("t4_lim_off", 32'd0, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, pk(1'b0, 1'b0, 5'd1, 1'b0), NOCHAN);

    // Asynchronous reset mid-count (count 7), then the count restarts from 0.
    do_reset();
    step("t5_arm", 32'd10, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), FULL);
    for (int j = 0; j < 7; j++) begin
      step("t5_count", 32'd10, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), FULL);
    end
    do_reset();
    step("t5_rearm", 32'd10, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, pk(1'b1, 1'b0, 5'd0, 1'b0), FULL);
    for (int j = 0; j < 10; j++) begin
      step("t5_restart", 32'd10, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0,
           pk(j < 9, j == 9, 5'd0, j == 9), FULL);
    end

    // 4-bit counter saturates at 15: limit 100 and 16 never trip, limit 15 trips next edge.
    do_reset();
    step("t6_arm", 32'd100, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, pk(1'b1, 1'b0, 5'd0, 1'b0), FULL);
    for (int j = 0; j < 40; j++) begin
      step("t6_sat", 32'd100, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, pk(1'b1, 1'b0, 5'd0, 1'b0), FULL);
    end
    for (int j = 0; j < 5; j++) begin
      step("t6_lim16", 32'd16, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, pk(1'b1, 1'b0, 5'd0, 1'b0), FULL);
    end
    step("t6_lim15", 32'd15, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, pk(1'b0, 1'b1, 5'd0, 1'b1), FULL);
    step("t6_hold", 32'd15, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, pk(1'b0, 1'b1, 5'd0, 1'b0), FULL);

    // final report
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
